// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit
// Decodes the opcode held in IF/ID, registers the control word and rt into
// ID/EX, detects load-use hazards against the ID/EX instruction and squashes
// the decode slot on taken branches. addi, bne and j decode only when EXT_ISA
// is set; otherwise they are reported as illegal.
module pipelined_control_unit #(
    parameter int INSTR_WIDTH    = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int EXT_ISA        = 1,
    parameter int HAZARD_EN      = 1
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic [INSTR_WIDTH-1:0]    Instruction,
    input  logic                      InstrValid,
    input  logic                      BranchTaken,
    output logic                      RegDst,
    output logic                      ALUSrc,
    output logic                      Branch,
    output logic                      BranchNe,
    output logic                      Jump,
    output logic                      MemRead,
    output logic                      MemWrite,
    output logic                      MemtoReg,
    output logic                      RegWrite,
    output logic [1:0]                ALUOp,
    output logic [REG_ADDR_WIDTH-1:0] IdExRt,
    output logic                      Stall,
    output logic                      FlushIF,
    output logic                      IllegalOp
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam int RS_HI  = INSTR_WIDTH - 7;
    localparam int RT_HI  = RS_HI - REG_ADDR_WIDTH;
    localparam int LOW_HI = RT_HI - REG_ADDR_WIDTH;

    logic [5:0]                opcode_s;
    logic [REG_ADDR_WIDTH-1:0] rs_s;
    logic [REG_ADDR_WIDTH-1:0] rt_s;
    logic                      unused_low_bits_s;

    logic       dec_regdst_s;
    logic       dec_alusrc_s;
    logic       dec_branch_s;
    logic       dec_branchne_s;
    logic       dec_jump_s;
    logic       dec_memread_s;
    logic       dec_memwrite_s;
    logic       dec_memtoreg_s;
    logic       dec_regwrite_s;
    logic [1:0] dec_aluop_s;
    logic       dec_legal_s;
    logic       dec_uses_rt_s;
    logic       hazard_s;

    assign opcode_s          = Instruction[INSTR_WIDTH-1 -: 6];
    assign rs_s              = Instruction[RS_HI -: REG_ADDR_WIDTH];
    assign rt_s              = Instruction[RT_HI -: REG_ADDR_WIDTH];
    // Immediate/funct bits are consumed by later stages, not by this unit.
    assign unused_low_bits_s = ^Instruction[LOW_HI:0];

    // Opcode decode into the control word; flags whether rt is a source operand.
    always_comb begin
        dec_regdst_s   = 1'b0;
        dec_alusrc_s   = 1'b0;
        dec_branch_s   = 1'b0;
        dec_branchne_s = 1'b0;
        dec_jump_s     = 1'b0;
        dec_memread_s  = 1'b0;
        dec_memwrite_s = 1'b0;
        dec_memtoreg_s = 1'b0;
        dec_regwrite_s = 1'b0;
        dec_aluop_s    = 2'b00;
        dec_legal_s    = 1'b1;
        dec_uses_rt_s  = 1'b0;
        case (opcode_s)
            OP_RTYPE: begin
                dec_regdst_s   = 1'b1;
                dec_regwrite_s = 1'b1;
                dec_aluop_s    = 2'b10;
                dec_uses_rt_s  = 1'b1;
            end
            OP_LW: begin
                dec_alusrc_s   = 1'b1;
                dec_memread_s  = 1'b1;
                dec_memtoreg_s = 1'b1;
                dec_regwrite_s = 1'b1;
            end
            OP_SW: begin
                dec_alusrc_s   = 1'b1;
                dec_memwrite_s = 1'b1;
                dec_uses_rt_s  = 1'b1;
            end
            OP_BEQ: begin
                dec_branch_s   = 1'b1;
                dec_aluop_s    = 2'b01;
                dec_uses_rt_s  = 1'b1;
            end
            OP_ADDI: begin
                if (EXT_ISA != 0) begin
                    dec_alusrc_s   = 1'b1;
                    dec_regwrite_s = 1'b1;
                end else begin
                    dec_legal_s    = 1'b0;
                end
            end
            OP_BNE: begin
                if (EXT_ISA != 0) begin
                    dec_branchne_s = 1'b1;
                    dec_aluop_s    = 2'b01;
                    dec_uses_rt_s  = 1'b1;
                end else begin
                    dec_legal_s    = 1'b0;
                end
            end
            OP_J: begin
                if (EXT_ISA != 0) begin
                    dec_jump_s     = 1'b1;
                end else begin
                    dec_legal_s    = 1'b0;
                end
            end
            default: begin
                dec_legal_s = 1'b0;
            end
        endcase
    end

    // Load-use hazard: the load in ID/EX writes a register the ID instruction reads.
    always_comb begin
        hazard_s = 1'b0;
        if ((HAZARD_EN != 0) && MemRead && (|IdExRt) && InstrValid) begin
            hazard_s = (IdExRt == rs_s) || (dec_uses_rt_s && (IdExRt == rt_s));
        end else begin
            hazard_s = 1'b0;
        end
    end

    assign Stall   = hazard_s;
    assign FlushIF = BranchTaken;

    // ID/EX register: squash on branch or stall, bubble on invalid/illegal, else load decode.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            RegDst    <= 1'b0;
            ALUSrc    <= 1'b0;
            Branch    <= 1'b0;
            BranchNe  <= 1'b0;
            Jump      <= 1'b0;
            MemRead   <= 1'b0;
            MemWrite  <= 1'b0;
            MemtoReg  <= 1'b0;
            RegWrite  <= 1'b0;
            ALUOp     <= 2'b00;
            IdExRt    <= {REG_ADDR_WIDTH{1'b0}};
            IllegalOp <= 1'b0;
        end else if (BranchTaken || hazard_s || !InstrValid || !dec_legal_s) begin
            RegDst    <= 1'b0;
            ALUSrc    <= 1'b0;
            Branch    <= 1'b0;
            BranchNe  <= 1'b0;
            Jump      <= 1'b0;
            MemRead   <= 1'b0;
            MemWrite  <= 1'b0;
            MemtoReg  <= 1'b0;
            RegWrite  <= 1'b0;
            ALUOp     <= 2'b00;
            IdExRt    <= {REG_ADDR_WIDTH{1'b0}};
            // Only an otherwise-accepted valid instruction can report illegality.
            IllegalOp <= !BranchTaken && !hazard_s && InstrValid && !dec_legal_s;
        end else begin
            RegDst    <= dec_regdst_s;
            ALUSrc    <= dec_alusrc_s;
            Branch    <= dec_branch_s;
            BranchNe  <= dec_branchne_s;
            Jump      <= dec_jump_s;
            MemRead   <= dec_memread_s;
            MemWrite  <= dec_memwrite_s;
            MemtoReg  <= dec_memtoreg_s;
            RegWrite  <= dec_regwrite_s;
            ALUOp     <= dec_aluop_s;
            IdExRt    <= rt_s;
            IllegalOp <= 1'b0;
        end
    end

endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
- Second-generation MIPS control unit for the 5-stage pipeline.
- Decodes the opcode of the instruction in ID and registers the control word into the ID/EX stage.
- Detects load-use hazards against the instruction it already holds in ID/EX; squashes on taken branches.
- Extends the base ISA (R-type, lw, sw, beq) with addi, bne and j under a parameter.

Parameters:
INSTR_WIDTH, 32, instruction width; opcode = [INSTR_WIDTH-1 -: 6], rs = next REG_ADDR_WIDTH bits, rt = the REG_ADDR_WIDTH bits after rs
REG_ADDR_WIDTH, 5, register specifier width
EXT_ISA, 1, 1 = also decode addi (001000), bne (000101), j (000010); 0 = those opcodes are illegal
HAZARD_EN, 1, 1 = load-use detection active; 0 = Stall tied 0

Ports:
Clk  input  1  clock, all state on rising edge
Rst  input  1  asynchronous, active-high reset
Instruction  input  INSTR_WIDTH  IF/ID instruction
InstrValid  input  1  IF/ID holds a real instruction (0 = bubble)
BranchTaken  input  1  EX-stage branch resolved taken
RegDst, ALUSrc, Branch, BranchNe, Jump, MemRead, MemWrite, MemtoReg, RegWrite  output  1 each  ID/EX control, registered
ALUOp  output  2  ID/EX ALU op, registered: 00 add, 01 subtract, 10 use funct
IdExRt  output  REG_ADDR_WIDTH  registered rt of the ID/EX instruction
Stall  output  1  combinational; holds PC and IF/ID
FlushIF  output  1  combinational; equals BranchTaken, zeroes IF/ID
IllegalOp  output  1  registered one-cycle pulse: illegal opcode decoded

Behaviour:
- Reset (async, any time): all registered outputs and IdExRt go to 0, including mid-stall or mid-flush. First rising edge after Rst deasserts performs a normal update.
- Decode truth table (RegDst, ALUSrc, MemRead, MemWrite, MemtoReg, RegWrite, ALUOp); Branch/BranchNe/Jump = 0 unless stated:
  - R-type 000000: 1,0,0,0,0,1,10
  - lw 100011: 0,1,1,0,1,1,00
  - sw 101011: 0,1,0,1,0,0,00
  - beq 000100: 0,0,0,0,0,0,01, Branch=1
  - addi 001000 (EXT_ISA): 0,1,0,0,0,1,00
  - bne 000101 (EXT_ISA): as beq, but BranchNe=1 and Branch=0
  - j 000010 (EXT_ISA): all zero except Jump=1
  - Any other opcode: bubble, with IllegalOp=1 next cycle if InstrValid=1.
- Bubble: all control outputs 0, IdExRt = 0, ALUOp = 00.
- Hazard condition (HAZARD_EN=1): registered MemRead=1 and IdExRt != 0 and InstrValid=1, and IdExRt equals rs of the current instruction, or equals rt when the current op is R-type, sw, beq or bne.
  - When it holds, Stall=1 in the same cycle and a bubble is registered at the next edge.
  - Stall lasts exactly one cycle, because the bubble clears MemRead.
- Per-edge priority:
  1. BranchTaken=1: bubble registered, IllegalOp=0.
  2. Stall: bubble registered, IllegalOp=0.
  3. InstrValid=0: bubble registered.
  4. Otherwise: decoded word and rt are registered.
- Simultaneous BranchTaken and hazard: Stall is still driven combinationally; IF/ID is flushed, so the next cycle has no hazard.
- Latency: decode to outputs is 1 cycle. FlushIF and Stall are 0-cycle combinational.
- The unit holds no state other than the ID/EX register and IllegalOp.

Test Plan:
1. Rst=1 during an lw decode, then release → all outputs 0 on release; the next edge shows lw word MemRead=1, MemtoReg=1, RegWrite=1, ALUSrc=1, ALUOp=00.
2. Sequence add, lw, sw, beq (valid, no hazard) → one edge each; outputs match the table exactly, with Branch=1 and ALUOp=01 for beq.
3. lw $8 followed by add $9,$8,$2 → Stall=1 for exactly one cycle and a bubble registered; add's word appears one cycle later. Repeat with lw $0 → no stall.
4. BranchTaken=1 while IF/ID holds sw → FlushIF=1; bubble registered (MemWrite=0).
5. EXT_ISA=1: addi, bne, j → RegWrite=1/ALUSrc=1; BranchNe=1/ALUOp=01; Jump=1. With EXT_ISA=0 the same opcodes give a bubble and a one-cycle IllegalOp pulse; opcode 111111 pulses IllegalOp in both builds.
6. Hazard plus BranchTaken on the same cycle, then InstrValid=0 → bubble, no IllegalOp, Stall cleared next cycle.
